// File: rtl/stream_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// stream_scoreboard_pkg
//   Shared definitions for the stream scoreboard: the verdict FSM encoding.
//   SB_RUN  : no error recorded, ok=1
//   SB_FAIL : at least one error recorded since reset/clr, ok=0
// -----------------------------------------------------------------------------
package stream_scoreboard_pkg;

    typedef enum logic {
        SB_RUN  = 1'b0,
        SB_FAIL = 1'b1
    } sb_state_e;

endpackage : stream_scoreboard_pkg

// File: rtl/scoreboard_fifo.sv
// -----------------------------------------------------------------------------
// scoreboard_fifo
//   Synchronous show-ahead FIFO, WIDTH x 2^DEPTH_LOG2 (DEPTH_LOG2 >= 1).
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate count register.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push/din   : write din when push && !full
//   pop        : advance head when pop && !empty
//   flush      : synchronous empty; overrides push/pop in the same cycle
//   dout       : current head entry (valid when !empty)
//   level      : number of stored entries, 0..2^DEPTH_LOG2
//   full/empty : status derived from the registered pointers only
// -----------------------------------------------------------------------------
module scoreboard_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2:0]   r_wptr;
    logic [DEPTH_LOG2:0]   r_rptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty = (r_wptr == r_rptr);
    // Same slot, opposite lap: the writer is exactly one lap ahead.
    assign full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign level = r_wptr - r_rptr;
    assign dout  = r_mem[r_rptr[DEPTH_LOG2-1:0]];

    assign w_do_push = push && !full  && !flush;
    assign w_do_pop  = pop  && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule : scoreboard_fifo

// File: rtl/stream_scoreboard.sv
// -----------------------------------------------------------------------------
// stream_scoreboard
//   Buffers expected beats and compares them in order against actual DUT
//   beats. Produces a single ok level for a downstream assertion checker,
//   sticky error flags and saturating match/error counters.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous clear (FIFO, flags, counters, FSM)
//   exp_valid/data : expected beat in; accepted when exp_ready
//   exp_ready      : !full, from registered state only
//   act_valid/data : actual beat in; always consumed
//   ok             : 1 while no error has been recorded
//   err_*          : sticky mismatch / underflow / timeout flags
//   pending        : FIFO fill level
//   match_cnt      : successful compares (saturating)
//   err_cnt        : mismatches + underflows (saturating)
// Timing: a beat sampled at edge N is compared into a result register at N;
// flags, counters and ok reflect it after edge N+1.
// -----------------------------------------------------------------------------
module stream_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  exp_valid,
    input  logic [WIDTH-1:0]      exp_data,
    output logic                  exp_ready,
    input  logic                  act_valid,
    input  logic [WIDTH-1:0]      act_data,
    output logic                  ok,
    output logic                  err_mismatch,
    output logic                  err_underflow,
    output logic                  err_timeout,
    output logic [DEPTH_LOG2:0]   pending,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    import stream_scoreboard_pkg::*;

    localparam int                   TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]      TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // FIFO interface
    logic [WIDTH-1:0]    w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_uflow;
    logic                w_hit;

    // registered compare stage
    logic                r_cmp_vld;
    logic                r_cmp_hit;
    logic                r_cmp_uf;

    // events consumed by flags/counters/FSM
    logic                w_ev_match;
    logic                w_ev_mis;
    logic                w_ev_err;
    logic                w_to_run;
    logic                w_to_fire;

    logic [TO_W-1:0]     r_to_cnt;
    logic                r_err_mis;
    logic                r_err_uf;
    logic                r_err_to;
    logic [CNT_WIDTH-1:0] r_match_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    sb_state_e           r_state;
    sb_state_e           w_state_nxt;
    logic                w_ok;

    // No bypass: an actual beat against an empty FIFO is an underflow even
    // if an expected beat is being pushed on the same edge.
    assign w_push  = exp_valid && !w_full  && !clr;
    assign w_pop   = act_valid && !w_empty && !clr;
    assign w_uflow = act_valid &&  w_empty && !clr;
    // Four-state compare so X/Z on the actual stream never passes.
    assign w_hit   = !(w_head !== act_data);

    scoreboard_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (clr),
        .din   (exp_data),
        .dout  (w_head),
        .level (pending),
        .full  (w_full),
        .empty (w_empty)
    );

    assign exp_ready = !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_vld <= 1'b0;
            r_cmp_hit <= 1'b0;
            r_cmp_uf  <= 1'b0;
        end else begin
            r_cmp_vld <= w_pop;
            r_cmp_hit <= w_pop && w_hit;
            r_cmp_uf  <= w_uflow;
        end
    end

    assign w_ev_match = r_cmp_vld &&  r_cmp_hit;
    assign w_ev_mis   = r_cmp_vld && !r_cmp_hit;
    assign w_ev_err   = w_ev_mis || r_cmp_uf;

    // Starvation timer: counts edges with a waiting head and no pop, then
    // parks at TIMEOUT so the flag fires exactly once per starvation.
    assign w_to_run  = !w_empty && !w_pop;
    assign w_to_fire = (TIMEOUT != 0) && w_to_run && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (clr || !w_to_run) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_mis   <= 1'b0;
            r_err_uf    <= 1'b0;
            r_err_to    <= 1'b0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (clr) begin
            r_err_mis   <= 1'b0;
            r_err_uf    <= 1'b0;
            r_err_to    <= 1'b0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_ev_mis)  r_err_mis <= 1'b1;
            if (r_cmp_uf)  r_err_uf  <= 1'b1;
            if (w_to_fire) r_err_to  <= 1'b1;
            if (w_ev_match && (r_match_cnt != CNT_MAX))
                r_match_cnt <= r_match_cnt + 1'b1;
            if (w_ev_err && (r_err_cnt != CNT_MAX))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SB_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ok        = 1'b1;
        case (r_state)
            SB_RUN: begin
                w_ok = 1'b1;
                if (w_ev_err || w_to_fire) w_state_nxt = SB_FAIL;
            end
            SB_FAIL: begin
                w_ok = 1'b0;
            end
            default: begin
                w_ok        = 1'b0;
                w_state_nxt = SB_RUN;
            end
        endcase
        if (clr) w_state_nxt = SB_RUN;
    end

    assign ok            = w_ok;
    assign err_mismatch  = r_err_mis;
    assign err_underflow = r_err_uf;
    assign err_timeout   = r_err_to;
    assign match_cnt     = r_match_cnt;
    assign err_cnt       = r_err_cnt;

endmodule : stream_scoreboard
